disk_drive_emu: RTL
===================

# disk_drive_emu

Drive-side endpoint of the IWM serial disk interface: emulates a 5.25"/SmartPort-class drive mechanism facing the controller's `rddata`/`wrdata`/`_wrreq`/`_enbl` pins. It serializes track nibbles from an upstream byte stream onto `rddata` as falling-edge flux pulses. It also decodes `wrdata` transitions from the controller back into nibbles. Sits between the IWM pins and the track-buffer logic.

## Interface
- `BIT_CELL`, 28: fclk cycles per bit cell (4 µs at 7 MHz).
- `PULSE_LEN`, 7: `rddata` low-pulse width in fclk cycles; must be below `BIT_CELL/2`.
- `fclk`  in  1  sole clock (7 MHz).
- `reset`  in  1  reset, asynchronous and active-high.
- `_enbl`  in  1  drive enable from controller, active low.
- `_wrreq`  in  1  write request from controller, active low.
- `wrdata`  in  1  serial write data; each transition is a 1 bit. Asynchronous to `fclk` in general.
- `wp`  in  1  write-protect switch state.
- `rd_byte`  in  8  next nibble to place on the disk.
- `rd_valid`  in  1  `rd_byte` is valid.
- `rd_ready`  out  1  nibble consumed this cycle if `rd_valid`.
- `rddata`  out  1  serial read data to controller; idles high.
- `wr_byte`  out  8  decoded nibble.
- `wr_valid`  out  1  one-cycle strobe for `wr_byte`.
- `sense`  out  1  equals `wp` while `_enbl` is low, else 1.
- `rd_starve`  out  8  saturating count of nibbles substituted by 0xFF.

## Operation
- Modes (evaluated every cycle, priority order): OFF (`_enbl`=1), WRITE (`_enbl`=0, `_wrreq`=0), READ otherwise.
- Read serializer states:
  - START: entered on reset, and whenever the mode is not READ.
  - SHIFT: loops over cells.
- START→SHIFT: on the first READ cycle. That cycle is a load cycle.
- SHIFT load cycle: occurs when `cell_cnt`=`BIT_CELL`-1 and `bit_cnt`=7.
  - In a load cycle `rd_ready`=1.
  - If `rd_valid`=1, the shifter takes `rd_byte`.
  - If `rd_valid`=0, the shifter loads 0xFF and `rd_starve` increments, saturating at 255.
- Bits go out MSB first. A 1 bit drives `rddata` low for `cell_cnt` 0..`PULSE_LEN`-1 of its cell. A 0 bit leaves `rddata` high.
- Byte period: exactly 8·`BIT_CELL` cycles, with no gap between bytes.
- Write decoder:
  - Synchronizes `wrdata` through 2 flops.
  - Detects either edge.
  - Keeps an interval timer (6 bits, saturating) and an 8-bit shifter.
- Decoder, on an edge:
  - If timer ≥ `BIT_CELL`/2, shift in 1.
  - Timer then clears to 0.
  - Edges closer than `BIT_CELL`/2 are ignored, apart from clearing the timer.
- Decoder, with no edge:
  - If timer ≥ 3·`BIT_CELL`/2, shift in 0 and set timer to `BIT_CELL`/2.
  - Otherwise increment the timer.
- Nibble framing: when shifter[7]=1, `wr_byte`←shifter, `wr_valid`=1 for one cycle, and shifter clears. Shifter clearing takes priority over a same-cycle shift.
- On entry to WRITE (`_wrreq` falling while enabled):
  - Decoder shifter and timer clear.
  - The synchronizer history is reloaded with the current `wrdata`, so no spurious edge is seen.
- Outside WRITE the decoder is held clear and `wr_valid`=0.
- In WRITE and OFF: `rddata`=1 and `rd_ready`=0.

## Timing
- Reset values:
  - `rddata`=1, `rd_ready`=0, `wr_valid`=0, `wr_byte`=0x00, `rd_starve`=0.
  - Serializer in START, decoder cleared.
  - Reset takes effect immediately (asynchronous).
- All outputs are registered except `sense` and `rd_ready`, which is decoded from registered state.
- Read latency: a nibble accepted in load cycle L produces its first pulse (if its MSB is 1) at cycle L+1. Its bit k cell begins at L+1+k·`BIT_CELL`.
- Mode change mid-byte: the partially sent nibble is dropped. On return to READ the next load happens immediately, with no catch-up.
- Decode latency: `wr_valid` rises 3 cycles after the `wrdata` edge that completes the nibble (2 sync stages plus 1 register).
- Controller cell jitter of ±`BIT_CELL`/2-1 cycles must decode correctly. A 29-cycle cell must decode correctly.

## Structure
- Shared package `disk_pkg` holds:
  - `BIT_CELL_7M`=28, `BIT_CELL_8M`=32.
  - Serializer state enum {START, SHIFT}.
  - Mode enum {OFF, READ, WRITE}.
- One sub-module, `nibble_decoder`: the synchronizer, interval timer and shifter, with ports `fclk`, `reset`, `clear`, `wrdata`, `wr_byte`, `wr_valid`.

## Test plan
- READ, `rd_valid`=1 with 0xD5 constant → pulses start at cells 0,1,3,5,7 (offsets 0,28,84,140,196 from load+1), each 7 cycles low; `rd_ready` every 224 cycles.
- `rd_valid`=0 for one load → 8 pulses 28 cycles apart, `rd_starve`=1; 300 starved loads → `rd_starve`=255.
- WRITE, `wrdata` encoding D5 AA 96 with 28-cycle cells, then the same stream with 29-cycle cells → `wr_valid` three times with 0xD5, 0xAA, 0x96.
- WRITE with 10-bit sync 0xFF+00 repeated 5 times, then 0xD5 → five 0xFF then 0xD5; no other strobes.
- `_wrreq` falls mid-read at bit 3 → `rddata`=1 next cycle; no `rd_ready` while low; `_wrreq` rises → `rd_ready` in the first READ cycle.
- `reset` pulsed mid-byte, asynchronous to `fclk` → `rddata`=1 and `rd_ready`=0 before the next edge; `rd_starve`=0; `sense` tracks `wp` only while `_enbl`=0.

Source files
------------

// File: rtl/disk_pkg.sv
// Shared types and constants for the IWM drive-side emulation.
package disk_pkg;

    localparam int unsigned BIT_CELL_7M = 28;
    localparam int unsigned BIT_CELL_8M = 32;
    localparam int unsigned TIMER_W     = 6;

    typedef enum logic {
        START,
        SHIFT
    } ser_state_e;

    typedef enum logic [1:0] {
        OFF,
        READ,
        WRITE
    } mode_e;

    // Priority: disabled drive beats write request.
    function automatic mode_e decode_mode(input logic enbl_n, input logic wrreq_n);
        if (enbl_n) begin
            return OFF;
        end
        if (!wrreq_n) begin
            return WRITE;
        end
        return READ;
    endfunction

endpackage

// File: rtl/nibble_decoder.sv
// Recovers nibbles from controller wrdata transitions: synchronizer,
// saturating interval timer and a self-framing 8-bit shifter.
module nibble_decoder
    import disk_pkg::*;
#(
    parameter int unsigned BIT_CELL = BIT_CELL_7M
) (
    input  logic       fclk,
    input  logic       reset,
    input  logic       clear,
    input  logic       wrdata,
    output logic [7:0] wr_byte,
    output logic       wr_valid
);

    localparam int unsigned HALF_CELL = BIT_CELL / 2;
    localparam int unsigned ZERO_TIME = (3 * BIT_CELL) / 2;

    // sync_q[1:0] are the synchronizer stages, sync_q[2] is edge history
    logic [2:0]         sync_q, sync_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         wr_byte_q, wr_byte_d;
    logic               wr_valid_q, wr_valid_d;
    logic               edge_c;
    logic               do_shift;
    logic [7:0]         shifted;

    assign edge_c = sync_q[2] ^ sync_q[1];

    always_comb begin
        sync_d     = {sync_q[1:0], wrdata};
        timer_d    = timer_q;
        shift_d    = shift_q;
        wr_byte_d  = wr_byte_q;
        wr_valid_d = 1'b0;
        do_shift   = 1'b0;
        shifted    = shift_q;
        if (clear) begin
            // Preload history with the live level so entry sees no edge
            sync_d  = {3{wrdata}};
            timer_d = '0;
            shift_d = '0;
        end else begin
            if (edge_c) begin
                timer_d = '0;
                if (timer_q >= TIMER_W'(HALF_CELL)) begin
                    shifted  = {shift_q[6:0], 1'b1};
                    do_shift = 1'b1;
                end
            end else if (timer_q >= TIMER_W'(ZERO_TIME)) begin
                shifted  = {shift_q[6:0], 1'b0};
                do_shift = 1'b1;
                timer_d  = TIMER_W'(HALF_CELL);
            end else if (timer_q != '1) begin
                timer_d = timer_q + TIMER_W'(1);
            end
            if (do_shift) begin
                if (shifted[7]) begin
                    wr_byte_d  = shifted;
                    wr_valid_d = 1'b1;
                    shift_d    = '0;
                end else begin
                    shift_d = shifted;
                end
            end
        end
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            timer_q    <= '0;
            shift_q    <= '0;
            wr_byte_q  <= '0;
            wr_valid_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            timer_q    <= timer_d;
            shift_q    <= shift_d;
            wr_byte_q  <= wr_byte_d;
            wr_valid_q <= wr_valid_d;
        end
    end

    assign wr_byte  = wr_byte_q;
    assign wr_valid = wr_valid_q;

endmodule

// File: rtl/disk_drive_emu.sv
// Drive-side IWM endpoint: serializes upstream nibbles onto rddata as
// low flux pulses and decodes wrdata transitions back into nibbles.
module disk_drive_emu
    import disk_pkg::*;
#(
    parameter int unsigned BIT_CELL  = BIT_CELL_7M,
    parameter int unsigned PULSE_LEN = 7
) (
    input  logic       fclk,
    input  logic       reset,
    input  logic       _enbl,
    input  logic       _wrreq,
    input  logic       wrdata,
    input  logic       wp,
    input  logic [7:0] rd_byte,
    input  logic       rd_valid,
    output logic       rd_ready,
    output logic       rddata,
    output logic [7:0] wr_byte,
    output logic       wr_valid,
    output logic       sense,
    output logic [7:0] rd_starve
);

    localparam int unsigned CELL_W = $clog2(BIT_CELL);

    mode_e             mode_c;
    ser_state_e        state_q, state_d;
    logic [CELL_W-1:0] cell_q, cell_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              rddata_q, rddata_d;
    logic [7:0]        starve_q, starve_d;
    logic              cell_last_c;
    logic              load_c;

    assign mode_c      = decode_mode(_enbl, _wrreq);
    assign cell_last_c = (cell_q == CELL_W'(BIT_CELL - 1));
    assign load_c      = !reset && (mode_c == READ)
                         && ((state_q == START) || (cell_last_c && (bit_q == 3'd7)));

    // Serializer: MSB-first cells, pulse at the head of each 1 cell
    always_comb begin
        state_d  = state_q;
        cell_d   = cell_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        starve_d = starve_q;
        rddata_d = 1'b1;
        if (mode_c != READ) begin
            state_d = START;
            cell_d  = '0;
            bit_d   = '0;
        end else begin
            state_d = SHIFT;
            if (load_c) begin
                cell_d = '0;
                bit_d  = '0;
                if (rd_valid) begin
                    shift_d = rd_byte;
                end else begin
                    shift_d = 8'hFF;
                    if (starve_q != 8'hFF) begin
                        starve_d = starve_q + 8'd1;
                    end
                end
            end else if (cell_last_c) begin
                cell_d  = '0;
                bit_d   = bit_q + 3'd1;
                shift_d = {shift_q[6:0], 1'b0};
            end else begin
                cell_d = cell_q + CELL_W'(1);
            end
            rddata_d = !(shift_d[7] && (cell_d < CELL_W'(PULSE_LEN)));
        end
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state_q  <= START;
            cell_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            rddata_q <= 1'b1;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cell_q   <= cell_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            rddata_q <= rddata_d;
            starve_q <= starve_d;
        end
    end

    nibble_decoder #(
        .BIT_CELL (BIT_CELL)
    ) u_decoder (
        .fclk     (fclk),
        .reset    (reset),
        .clear    (mode_c != WRITE),
        .wrdata   (wrdata),
        .wr_byte  (wr_byte),
        .wr_valid (wr_valid)
    );

    assign rd_ready  = load_c;
    assign rddata    = rddata_q;
    assign rd_starve = starve_q;
    assign sense     = _enbl ? 1'b1 : wp;

endmodule
